// File: rtl/mcp_pkg.sv
// Multicycle MIPS main-control package.
// State encoding, opcodes, mux encodings and the control bundle.
package mcp_pkg;

  localparam int OPW = 6;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_BRANCHNE = 4'd12
  } state_e;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_we;
    logic       branch;
    logic       branch_ne;
    logic       instr_or_data;
    logic       instr_we;
    logic       wmem;
    logic       wrf;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       a_sel;
    logic [1:0] b_sel;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       done;
  } ctrl_t;

endpackage

// File: rtl/mcp_state_decoder.sv
// Moore decode of the main-control state into datapath controls.
// Purely combinational; no opcode dependence.
module mcp_state_decoder
  import mcp_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  // per-state control word, everything not listed stays 0
  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.instr_we = 1'b1;
        ctrl_o.pc_we    = 1'b1;
        ctrl_o.b_sel    = SRCB_FOUR;
        ctrl_o.alu_op   = ALUOP_ADD;
        ctrl_o.pc_src   = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl_o.b_sel  = SRCB_BRIMM;
        ctrl_o.alu_op = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl_o.a_sel  = 1'b1;
        ctrl_o.b_sel  = SRCB_IMM;
        ctrl_o.alu_op = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.instr_or_data = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.wrf        = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.done       = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.instr_or_data = 1'b1;
        ctrl_o.wmem          = 1'b1;
        ctrl_o.done          = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_o.a_sel  = 1'b1;
        ctrl_o.b_sel  = SRCB_REG;
        ctrl_o.alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.wrf     = 1'b1;
        ctrl_o.reg_dst = 1'b1;
        ctrl_o.done    = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.a_sel  = 1'b1;
        ctrl_o.b_sel  = SRCB_REG;
        ctrl_o.alu_op = ALUOP_SUB;
        ctrl_o.pc_src = PCSRC_ALUOUT;
        ctrl_o.branch = 1'b1;
        ctrl_o.done   = 1'b1;
      end
      S_BRANCHNE: begin
        ctrl_o.a_sel     = 1'b1;
        ctrl_o.b_sel     = SRCB_REG;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_src    = PCSRC_ALUOUT;
        ctrl_o.branch_ne = 1'b1;
        ctrl_o.done      = 1'b1;
      end
      S_ADDIEX: begin
        ctrl_o.a_sel  = 1'b1;
        ctrl_o.b_sel  = SRCB_IMM;
        ctrl_o.alu_op = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl_o.wrf  = 1'b1;
        ctrl_o.done = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_src = PCSRC_JUMP;
        ctrl_o.pc_we  = 1'b1;
        ctrl_o.done   = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mcp_main_fsm.sv
// Multicycle MIPS main control FSM (state reg, dispatch, reset gating).
// Optional bne support: define MCP_BNE_EN.
module mcp_main_fsm
  import mcp_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic [OPW-1:0] opcode_i6,
  output logic           pc_we_o,
  output logic           branch_o,
  output logic           branch_ne_o,
  output logic           instr_or_data_o,
  output logic           instr_we_o,
  output logic           enable_wmem_o,
  output logic           enable_wrf_o,
  output logic           reg_dst_o,
  output logic           mem_to_reg_o,
  output logic           a_alu_input_o,
  output logic [1:0]     b_alu_input_o2,
  output logic [1:0]     alu_op_o2,
  output logic [1:0]     pc_src_o2,
  output logic           instr_done_o,
  output logic           illegal_op_o,
  output logic [3:0]     state_o4
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   illegal;
  logic   run;

  // state register, synchronous reset back to FETCH
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  // next-state and opcode dispatch
  always_comb begin
    state_d = S_FETCH;
    illegal = 1'b0;
    unique case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        case (opcode_i6)
          OP_LW,
          OP_SW:    state_d = S_MEMADR;
          OP_RTYPE: state_d = S_EXECUTE;
          OP_BEQ:   state_d = S_BRANCH;
          OP_ADDI:  state_d = S_ADDIEX;
          OP_J:     state_d = S_JUMP;
`ifdef MCP_BNE_EN
          OP_BNE:   state_d = S_BRANCHNE;
`endif
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (opcode_i6 == OP_SW) state_d = S_MEMWR;
        else                    state_d = S_MEMRD;
      end
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  mcp_state_decoder u_dec (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  // write strobes and pulses are suppressed while reset is held
  assign run = ~reset_i;

  assign pc_we_o         = ctrl.pc_we & run;
  assign branch_o        = ctrl.branch & run;
  assign instr_we_o      = ctrl.instr_we & run;
  assign enable_wmem_o   = ctrl.wmem & run;
  assign enable_wrf_o    = ctrl.wrf & run;
  assign instr_done_o    = ctrl.done & run;
  assign illegal_op_o    = illegal & run;
  assign instr_or_data_o = ctrl.instr_or_data;
  assign reg_dst_o       = ctrl.reg_dst;
  assign mem_to_reg_o    = ctrl.mem_to_reg;
  assign a_alu_input_o   = ctrl.a_sel;
  assign b_alu_input_o2  = ctrl.b_sel;
  assign alu_op_o2       = ctrl.alu_op;
  assign pc_src_o2       = ctrl.pc_src;
  assign state_o4        = state_q;

`ifdef MCP_BNE_EN
  assign branch_ne_o = ctrl.branch_ne & run;
`else
  logic unused_bne;
  assign unused_bne  = ctrl.branch_ne;
  assign branch_ne_o = 1'b0;
`endif

endmodule

// File: tb/tb_mcp_main_fsm.sv
// Scoreboard bench for mcp_main_fsm.
// Stimulus pushes hand-built control words; a negedge monitor pops and compares.
module tb_mcp_main_fsm;
  import mcp_pkg::*;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [5:0] opcode_i6 = 6'b0;
  logic       pc_we_o, branch_o, branch_ne_o, instr_or_data_o;
  logic       instr_we_o, enable_wmem_o, enable_wrf_o, reg_dst_o;
  logic       mem_to_reg_o, a_alu_input_o, instr_done_o, illegal_op_o;
  logic [1:0] b_alu_input_o2, alu_op_o2, pc_src_o2;
  logic [3:0] state_o4;

  int tests = 0;
  int failed = 0;
  int exp_done = 0;
  int dut_done = 0;
  logic [21:0] q[$];

  always #5 clk_i = ~clk_i;

  mcp_main_fsm dut (
    .clk_i(clk_i), .reset_i(reset_i), .opcode_i6(opcode_i6),
    .pc_we_o(pc_we_o), .branch_o(branch_o), .branch_ne_o(branch_ne_o),
    .instr_or_data_o(instr_or_data_o), .instr_we_o(instr_we_o),
    .enable_wmem_o(enable_wmem_o), .enable_wrf_o(enable_wrf_o),
    .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .a_alu_input_o(a_alu_input_o), .b_alu_input_o2(b_alu_input_o2),
    .alu_op_o2(alu_op_o2), .pc_src_o2(pc_src_o2),
    .instr_done_o(instr_done_o), .illegal_op_o(illegal_op_o),
    .state_o4(state_o4)
  );

  // word: st4 pcwe br bne iod iwe wmem wrf rdst m2r a b2 alu2 pcs2 done ill
  function automatic logic [21:0] ev(input logic [3:0] st, input bit rst,
                                     input bit ill);
    logic pcwe, br, bne, iod, iwe, wm, wrf, rd, m2r, a, dn, il;
    logic [1:0] b, alu, pcs;
    {pcwe, br, bne, iod, iwe, wm, wrf, rd, m2r, a, dn, il} = '0;
    b = 2'b00; alu = 2'b00; pcs = 2'b00;
    case (st)
      4'd0:  begin iwe = 1; pcwe = 1; b = 2'b01; end
      4'd1:  begin b = 2'b11; il = ill; end
      4'd2:  begin a = 1; b = 2'b10; end
      4'd3:  begin iod = 1; end
      4'd4:  begin wrf = 1; m2r = 1; dn = 1; end
      4'd5:  begin iod = 1; wm = 1; dn = 1; end
      4'd6:  begin a = 1; alu = 2'b10; end
      4'd7:  begin wrf = 1; rd = 1; dn = 1; end
      4'd8:  begin a = 1; alu = 2'b01; pcs = 2'b01; br = 1; dn = 1; end
      4'd9:  begin a = 1; b = 2'b10; end
      4'd10: begin wrf = 1; dn = 1; end
      4'd11: begin pcs = 2'b10; pcwe = 1; dn = 1; end
      4'd12: begin a = 1; alu = 2'b01; pcs = 2'b01; bne = 1; dn = 1; end
      default: ;
    endcase
    if (rst) {pcwe, br, bne, iwe, wm, wrf, dn, il} = '0;
    return {st, pcwe, br, bne, iod, iwe, wm, wrf, rd, m2r, a,
            b, alu, pcs, dn, il};
  endfunction

  task automatic cyc(input bit r, input logic [5:0] op,
                     input logic [3:0] st, input bit ill);
    logic [21:0] e;
    @(posedge clk_i);
    #1;
    reset_i = r;
    opcode_i6 = op;
    e = ev(st, r, ill);
    q.push_back(e);
    if (e[1]) exp_done++;
  endtask

  // seq holds n states, first state in the low nibble
  task automatic run(input logic [5:0] op, input int n,
                     input logic [19:0] seq, input bit ill);
    for (int i = 0; i < n; i++)
      cyc(1'b0, op, seq[4*i +: 4], ill && (i == 1));
  endtask

  // monitor: compare each presented control word against the scoreboard
  always @(negedge clk_i) begin
    logic [21:0] act, e;
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {state_o4, pc_we_o, branch_o, branch_ne_o, instr_or_data_o,
             instr_we_o, enable_wmem_o, enable_wrf_o, reg_dst_o,
             mem_to_reg_o, a_alu_input_o, b_alu_input_o2, alu_op_o2,
             pc_src_o2, instr_done_o, illegal_op_o};
      if (instr_done_o) dut_done++;
      tests++;
      if (act !== e) begin
        failed++;
        $display("FAIL ctl t=%0t got=%h want=%h", $time, act, e);
      end
    end
  end

  initial begin
    // two reset edges, the second observed with strobes gated
    cyc(1'b1, 6'b100011, 4'd0, 1'b0);
    // lw: F D MA MRD MWB
    run(6'b100011, 5, 20'h43210, 1'b0);
    // sw: F D MA MWR
    run(6'b101011, 4, 20'h05210, 1'b0);
    // R-type: F D EX ALUWB
    run(6'b000000, 4, 20'h07610, 1'b0);
    // addi: F D AIEX AIWB
    run(6'b001000, 4, 20'h0a910, 1'b0);
    // beq then j
    run(6'b000100, 3, 20'h00810, 1'b0);
    run(6'b000010, 3, 20'h00b10, 1'b0);
`ifdef MCP_BNE_EN
    run(6'b000101, 3, 20'h00c10, 1'b0);
`else
    run(6'b000101, 2, 20'h00010, 1'b1);
`endif
    // unsupported opcode
    run(6'b111111, 2, 20'h00010, 1'b1);
    // lw abandoned by reset in MEMRD
    cyc(1'b0, 6'b100011, 4'd0, 1'b0);
    cyc(1'b0, 6'b100011, 4'd1, 1'b0);
    cyc(1'b0, 6'b100011, 4'd2, 1'b0);
    cyc(1'b1, 6'b100011, 4'd3, 1'b0);
    cyc(1'b1, 6'b100011, 4'd0, 1'b0);
    // recovery with an R-type
    run(6'b000000, 4, 20'h07610, 1'b0);
    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk_i);
    #1;
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    tests++;
    if (dut_done != exp_done) begin
      failed++;
      $display("FAIL done_count got=%0d want=%0d", dut_done, exp_done);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
